uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares one UART transmitter between N requesters; sits between client blocks and the UART TX.
// - Arbitrates round-robin, latches the winner's word, pulses tx enable, then tracks tx_busy to frame end.
// - Flags a transmitter that never goes busy after launch, then drops that frame.
// PARAMETERS
// - N_REQ    4   number of requesters, 2..8
// - D_WIDTH  13  data word width; must match the UART TX d_width
// - TIMEOUT  7   cycles in WAIT_BUSY before a launch is declared failed, 1..255
// PORTS
// - clk           in   1            rising-edge clock
// - rst_n         in   1            asynchronous, active-low reset
// - req_valid     in   N_REQ        per-requester request; held until matching req_ready pulse
// - req_data      in   N_REQ*D_WIDTH  requester i word at [i*D_WIDTH +: D_WIDTH]; stable while req_valid
// - req_ready     out  N_REQ        one-cycle accept pulse, at most one bit set
// - uart_tx_ena   out  1            one-cycle launch pulse to the UART TX
// - uart_tx_data  out  D_WIDTH      latched word; stable from launch until return to IDLE
// - uart_tx_busy  in   1            UART TX busy flag
// - grant_id      out  clog2(N_REQ)  index of current or last granted requester
// - active        out  1            high in every state except IDLE
// - err_timeout   out  1            one-cycle pulse when a launch times out
// - err_id        out  clog2(N_REQ)  requester of the last timed-out frame; holds until next error
// BEHAVIOUR
// - Reset (async, rst_n=0), all outputs 0:
//   - state=IDLE, wait counter=0, last_grant=N_REQ-1, so requester 0 has first priority.
//   - uart_tx_ena drops immediately even mid-frame; the in-flight frame is abandoned, no req_ready re-issued.
// - FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; all outputs registered.
// - IDLE, on an edge where |req_valid and uart_tx_busy==0:
//   - Winner = first set bit scanning last_grant+1 .. last_grant+N_REQ, modulo N_REQ.
//   - Latch uart_tx_data <= winner word; grant_id, last_grant <= winner; -> LAUNCH.
// - IDLE, other cases:
//   - uart_tx_busy==1: no grant, stay IDLE (external/residual busy).
//   - No request: stay IDLE, outputs hold.
// - LAUNCH, exactly one cycle:
//   - uart_tx_ena=1 and req_ready[winner]=1 in the same cycle; counter<=0; -> WAIT_BUSY.
//   - Requester may drop req_valid or change data on the next cycle.
// - WAIT_BUSY:
//   - uart_tx_busy=1: -> WAIT_DONE.
//   - Else counter+1; busy still 0 when counter==TIMEOUT-1: err_timeout pulse, err_id<=grant_id, -> IDLE.
//   - Timed-out frame is not retried; requester was already acked.
// - WAIT_DONE:
//   - uart_tx_busy=0: -> IDLE.
//   - Earliest next LAUNCH is 2 cycles after busy falls (IDLE arbitration edge, then LAUNCH).
// - Fairness: last_grant updates only at a grant, including timed-out frames.
//   - A continuously requesting client waits at most N_REQ-1 frames.
// - Request rules:
//   - req_valid dropped before ack: allowed only while not the winner; ignored at the next arbitration.
//   - req_valid rising in any state other than IDLE: waits for the next IDLE arbitration.
// - Counter width clog2(TIMEOUT+1); saturates, never wraps.
// TESTING
// - Reset; only req 2 valid, data 13'h0ABC, UART model busy for 16 cycles from ena+1:
//   - -> ena once, req_ready=4'b0100, uart_tx_data=13'h0ABC, active for 1+1+16 cycles.
// - All 4 requesting continuously for 8 frames:
//   - -> grant order 0,1,2,3,0,1,2,3; each req_ready pulses exactly twice.
// - UART model never asserts busy, TIMEOUT=7, req 1 valid:
//   - -> err_timeout pulse 7 cycles after WAIT_BUSY entry, err_id=1; next grant goes to req 2 if valid.
// - uart_tx_busy forced high in IDLE with req 0 valid:
//   - -> no grant until busy falls; grant on the first edge with busy=0.
// - rst_n asserted mid-WAIT_DONE:
//   - -> uart_tx_ena, active, req_ready go 0 asynchronously.
//   - After release, req 0 is granted first when 0 and 3 are both valid.
// - Req 3 raises valid during WAIT_DONE of a req 0 frame:
//   - -> req 3 is granted at the first IDLE arbitration; ena 2 cycles after busy falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ requesters. A round-robin pick
//   happens in IDLE. The winning word is latched, and the UART gets a one-cycle
//   enable while the winner gets a one-cycle accept. The block then waits for
//   tx_busy to rise and fall. If busy never rises within TIMEOUT cycles, the
//   frame is flagged and dropped.
// Ports
//   i_clk, i_rst_n     clock, async active-low reset
//   i_req_valid        per-requester request, held until its o_req_ready pulse
//   i_req_data         requester i word at [i*D_WIDTH +: D_WIDTH]
//   o_req_ready        one-cycle accept pulse (one-hot or zero)
//   o_uart_tx_ena      one-cycle launch pulse to the UART TX
//   o_uart_tx_data     latched word, stable from launch until back in IDLE
//   i_uart_tx_busy     UART TX busy flag
//   o_grant_id         current / last granted requester
//   o_active           high in every state except IDLE
//   o_err_timeout      one-cycle pulse when a launch times out
//   o_err_id           requester of the last timed-out frame
module uart_tx_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int D_WIDTH = 13,
  parameter  int TIMEOUT = 7,
  localparam int GW      = $clog2(N_REQ),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]   i_req_data,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_uart_tx_ena,
  output logic [D_WIDTH-1:0]         o_uart_tx_data,
  input  logic                       i_uart_tx_busy,
  output logic [GW-1:0]              o_grant_id,
  output logic                       o_active,
  output logic                       o_err_timeout,
  output logic [GW-1:0]              o_err_id
);

  localparam int IW = GW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                           r_state;
  logic [CW-1:0]                    r_cnt;
  logic [GW-1:0]                    r_last_grant;
  logic [N_REQ-1:0]                 r_req_ready;
  logic                             r_uart_tx_ena;
  logic [D_WIDTH-1:0]               r_uart_tx_data;
  logic [GW-1:0]                    r_grant_id;
  logic                             r_active;
  logic                             r_err_timeout;
  logic [GW-1:0]                    r_err_id;

  logic [N_REQ-1:0][D_WIDTH-1:0]    w_words;
  logic [IW-1:0]                    w_idx;
  logic [GW-1:0]                    w_win;
  logic                             w_found;

  assign w_words = i_req_data;

  // Round-robin scan starting just after the last grant, wrapping modulo N_REQ.
  // The sum stays below 2*N_REQ, so one conditional subtract is the modulo.
  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_last_grant} + IW'(k);
      if (w_idx >= IW'(N_REQ)) w_idx = w_idx - IW'(N_REQ);
      if (!w_found && i_req_valid[w_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_last_grant   <= GW'(N_REQ - 1);
      r_req_ready    <= '0;
      r_uart_tx_ena  <= 1'b0;
      r_uart_tx_data <= '0;
      r_grant_id     <= '0;
      r_active       <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_id       <= '0;
    end else begin
      // Pulses default low; they are raised only for the single cycle that needs them.
      r_req_ready   <= '0;
      r_uart_tx_ena <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Busy seen in IDLE is external or left over from a frame, so no grant is made.
          if (w_found && !i_uart_tx_busy) begin
            r_uart_tx_data <= w_words[w_win];
            r_grant_id     <= w_win;
            r_last_grant   <= w_win;
            r_uart_tx_ena  <= 1'b1;
            r_req_ready    <= N_REQ'(1) << w_win;
            r_active       <= 1'b1;
            r_state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_uart_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            // The requester was already acked, so the frame is dropped, not retried.
            r_err_timeout <= 1'b1;
            r_err_id      <= r_grant_id;
            r_active      <= 1'b0;
            r_state       <= S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!i_uart_tx_busy) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_uart_tx_ena  = r_uart_tx_ena;
  assign o_uart_tx_data = r_uart_tx_data;
  assign o_grant_id     = r_grant_id;
  assign o_active       = r_active;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_id       = r_err_id;

endmodule
